// File: rtl/ef_bus_arb.sv
// Shared external bus arbiter for a flash and a LAN91C111: round-robin grant,
// fixed setup/strobe/hold timing and one dead TURN cycle between transfers.
module ef_bus_arb #(
  parameter int AW     = 23,
  parameter int DW     = 32,
  parameter int SETUP  = 1,
  parameter int HOLD   = 1,
  parameter int FL_STB = 4,
  parameter int EN_STB = 3
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        req,
  input  logic [1:0]        we,
  input  logic [3:0]        be,
  input  logic [2*AW-1:0]   adr,
  input  logic [2*DW-1:0]   wdt,
  output logic [1:0]        ack,
  output logic [DW-1:0]     rdt,
  output logic [AW-1:0]     bus_a,
  output logic [DW-1:0]     bus_d_o,
  output logic              bus_d_oe,
  input  logic [DW-1:0]     bus_d_i,
  output logic              flash_ce_n,
  output logic              flash_oe_n,
  output logic              flash_we_n,
  output logic              enet_rd_n,
  output logic              enet_wr_n,
  output logic [3:0]        enet_be_n
);

  localparam int MAX1 = (SETUP > HOLD) ? SETUP : HOLD;
  localparam int MAX2 = (FL_STB > EN_STB) ? FL_STB : EN_STB;
  localparam int MAXC = (MAX1 > MAX2) ? MAX1 : MAX2;
  localparam int CW   = (MAXC > 1) ? $clog2(MAXC) : 1;

  typedef enum logic [2:0] {S_IDLE, S_SETUP, S_STROBE, S_HOLD, S_TURN} state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic            g_q, g_d, last_q, last_d, we_q, we_d;
  logic [AW-1:0]   adr_q, adr_d;
  logic [DW-1:0]   wdt_q, wdt_d;
  logic [3:0]      be_q, be_d;

  logic            act_d, stb_d;
  logic [1:0]      ack_d;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    g_d     = g_q;
    last_d  = last_q;
    we_d    = we_q;
    adr_d   = adr_q;
    wdt_d   = wdt_q;
    be_d    = be_q;
    case (state_q)
      S_IDLE: begin
        if (|req) begin
          // On a tie the requester not granted last wins.
          g_d     = (req == 2'b11) ? ~last_q : req[1];
          last_d  = g_d;
          we_d    = we[g_d];
          adr_d   = g_d ? adr[2*AW-1:AW] : adr[AW-1:0];
          wdt_d   = g_d ? wdt[2*DW-1:DW] : wdt[DW-1:0];
          be_d    = be;
          state_d = S_SETUP;
          cnt_d   = CW'(SETUP - 1);
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_STROBE;
          cnt_d   = g_q ? CW'(EN_STB - 1) : CW'(FL_STB - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_STROBE: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = CW'(HOLD - 1);
        end else begin
          cnt_d = cnt_q - CW'(1);
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) state_d = S_TURN;
        else             cnt_d   = cnt_q - CW'(1);
      end
      default: state_d = S_IDLE;
    endcase

    act_d = (state_d == S_SETUP) || (state_d == S_STROBE) || (state_d == S_HOLD);
    stb_d = (state_d == S_STROBE);
    ack_d = '0;
    if ((state_d == S_HOLD) && (cnt_d == '0)) ack_d = g_d ? 2'b10 : 2'b01;
  end

  // Outputs are registered from next-state values so they align with the state cycle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= S_IDLE;
      cnt_q      <= '0;
      g_q        <= 1'b0;
      last_q     <= 1'b1;
      we_q       <= 1'b0;
      adr_q      <= '0;
      wdt_q      <= '0;
      be_q       <= '0;
      ack        <= '0;
      rdt        <= '0;
      bus_a      <= '0;
      bus_d_o    <= '0;
      bus_d_oe   <= 1'b0;
      flash_ce_n <= 1'b1;
      flash_oe_n <= 1'b1;
      flash_we_n <= 1'b1;
      enet_rd_n  <= 1'b1;
      enet_wr_n  <= 1'b1;
      enet_be_n  <= 4'hF;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      g_q        <= g_d;
      last_q     <= last_d;
      we_q       <= we_d;
      adr_q      <= adr_d;
      wdt_q      <= wdt_d;
      be_q       <= be_d;
      ack        <= ack_d;
      if ((state_q == S_STROBE) && (cnt_q == '0) && !we_q) rdt <= bus_d_i;
      bus_a      <= act_d ? adr_d : '0;
      bus_d_o    <= (act_d && we_d) ? wdt_d : '0;
      bus_d_oe   <= act_d && we_d;
      flash_ce_n <= !(act_d && !g_d);
      flash_oe_n <= !(stb_d && !g_d && !we_d);
      flash_we_n <= !(stb_d && !g_d && we_d);
      enet_rd_n  <= !(stb_d && g_d && !we_d);
      enet_wr_n  <= !(stb_d && g_d && we_d);
      enet_be_n  <= (act_d && g_d) ? ~be_d : 4'hF;
    end
  end

endmodule

// File: tb/tb_ef_bus_arb.sv
// Directed bench for ef_bus_arb: timing, arbitration, dead cycle and reset abort.
module tb_ef_bus_arb;
  localparam int AW = 23;
  localparam int DW = 32;

  logic            clk = 1'b0;
  logic            rst;
  logic [1:0]      req, we;
  logic [3:0]      be;
  logic [2*AW-1:0] adr;
  logic [2*DW-1:0] wdt;
  logic [1:0]      ack;
  logic [DW-1:0]   rdt, bus_d_o, bus_d_i;
  logic [AW-1:0]   bus_a;
  logic            bus_d_oe, flash_ce_n, flash_oe_n, flash_we_n, enet_rd_n, enet_wr_n;
  logic [3:0]      enet_be_n;

  ef_bus_arb #(.AW(AW), .DW(DW), .SETUP(1), .HOLD(1), .FL_STB(4), .EN_STB(3)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .be(be), .adr(adr), .wdt(wdt),
    .ack(ack), .rdt(rdt), .bus_a(bus_a), .bus_d_o(bus_d_o), .bus_d_oe(bus_d_oe),
    .bus_d_i(bus_d_i), .flash_ce_n(flash_ce_n), .flash_oe_n(flash_oe_n),
    .flash_we_n(flash_we_n), .enet_rd_n(enet_rd_n), .enet_wr_n(enet_wr_n),
    .enet_be_n(enet_be_n)
  );

  always #5 clk = ~clk;

  int n_chk = 0;
  int n_fail = 0;

  int idx, n_ce, n_oe, n_we, n_rd, n_wr, n_doe, n_en, overlap, dead_viol;
  int prev_sel;
  int ack_t[$];
  logic [1:0] ack_w[$];
  logic       ce_a [64];
  logic       doe_a[64];
  logic       oe_a [64];
  logic [3:0] ben_a[64];
  logic [3:0] ben_sel;
  logic [AW-1:0] bus_a_sel;
  logic [DW-1:0] bus_d_sel;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic mon_clear();
    idx = 0; n_ce = 0; n_oe = 0; n_we = 0; n_rd = 0; n_wr = 0; n_doe = 0; n_en = 0;
    overlap = 0; dead_viol = 0; prev_sel = 0;
    ack_t.delete(); ack_w.delete();
    ben_sel = 'x; bus_a_sel = 'x; bus_d_sel = 'x;
  endtask

  task automatic mon_run(input int n);
    int sel;
    repeat (n) begin
      @(posedge clk); #1;
      idx++;
      if (idx < 64) begin
        ce_a[idx] = flash_ce_n; doe_a[idx] = bus_d_oe;
        oe_a[idx] = flash_oe_n; ben_a[idx] = enet_be_n;
      end
      if (!flash_ce_n) n_ce++;
      if (!flash_oe_n) n_oe++;
      if (!flash_we_n) n_we++;
      if (!enet_rd_n)  n_rd++;
      if (!enet_wr_n)  n_wr++;
      if (bus_d_oe)    n_doe++;
      if (enet_be_n != 4'hF) begin
        n_en++; ben_sel = enet_be_n;
      end
      if (!flash_ce_n || enet_be_n != 4'hF) begin
        bus_a_sel = bus_a;
        if (bus_d_oe) bus_d_sel = bus_d_o;
      end
      if (!flash_ce_n && enet_be_n != 4'hF) overlap++;
      sel = !flash_ce_n ? 1 : (enet_be_n != 4'hF) ? 2 : 0;
      if (sel != 0 && prev_sel != 0 && sel != prev_sel) dead_viol++;
      prev_sel = sel;
      if (ack != 2'b00) begin
        ack_t.push_back(idx); ack_w.push_back(ack);
      end
    end
  endtask

  initial begin
    rst = 1'b1; req = '0; we = '0; be = '0; adr = '0; wdt = '0; bus_d_i = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ce_n",  flash_ce_n, 1'b1);
    chk("rst_strobes", {flash_oe_n, flash_we_n, enet_rd_n, enet_wr_n}, 4'hF);
    chk("rst_be_n",  enet_be_n, 4'hF);
    chk("rst_doe",   bus_d_oe, 1'b0);
    chk("rst_bus",   {bus_a, bus_d_o}, '0);
    chk("rst_ack",   ack, 2'b00);
    chk("rst_rdt",   rdt, 32'h0);
    @(posedge clk); #1;
    rst = 1'b0;
    mon_clear(); mon_run(2);

    // Flash read; req dropped right after grant, transfer must still finish
    adr = {23'h000456, 23'h000123}; bus_d_i = 32'hDEADBEEF; we = 2'b00; req = 2'b01;
    mon_clear(); mon_run(1); req = 2'b00; mon_run(9);
    chk("fr_ce_cycles", n_ce, 6);
    chk("fr_oe_cycles", n_oe, 4);
    chk("fr_bus_a", bus_a_sel, 23'h000123);
    chk("fr_no_write", n_we + n_doe + n_en, 0);
    chk("fr_ack_count", ack_t.size(), 1);
    if (ack_t.size() == 1) begin
      chk("fr_ack_time", ack_t[0], 6);
      chk("fr_ack_who", ack_w[0], 2'b01);
    end
    chk("fr_rdt", rdt, 32'hDEADBEEF);

    // Ethernet write
    be = 4'b0011; wdt = {32'h0000A5A5, 32'h11111111}; we = 2'b10; req = 2'b10;
    bus_d_i = 32'h55555555;
    mon_clear(); mon_run(1); req = 2'b00; mon_run(9);
    chk("ew_doe_cycles", n_doe, 5);
    chk("ew_wr_cycles", n_wr, 3);
    chk("ew_be_n", ben_sel, 4'b1100);
    chk("ew_bus_d", bus_d_sel, 32'h0000A5A5);
    chk("ew_bus_a", bus_a_sel, 23'h000456);
    chk("ew_no_flash", n_ce, 0);
    chk("ew_ack_count", ack_t.size(), 1);
    if (ack_t.size() == 1) begin
      chk("ew_ack_time", ack_t[0], 5);
      chk("ew_ack_who", ack_w[0], 2'b10);
    end
    chk("ew_rdt_kept", rdt, 32'hDEADBEEF);

    // Both requesters held: after the Ethernet write above, flash wins first
    we = 2'b00; be = 4'b1111; req = 2'b11;
    mon_clear(); mon_run(29); req = 2'b00; mon_run(4);
    chk("rr_ack_count", ack_t.size(), 4);
    if (ack_t.size() == 4) begin
      chk("rr_who0", ack_w[0], 2'b01); chk("rr_t0", ack_t[0], 6);
      chk("rr_who1", ack_w[1], 2'b10); chk("rr_t1", ack_t[1], 13);
      chk("rr_who2", ack_w[2], 2'b01); chk("rr_t2", ack_t[2], 21);
      chk("rr_who3", ack_w[3], 2'b10); chk("rr_t3", ack_t[3], 28);
    end
    chk("rr_turn_sel", {ce_a[7], ben_a[7], ce_a[14], ben_a[14]}, 10'h3FF);
    chk("rr_overlap", overlap, 0);
    chk("rr_dead", dead_viol, 0);
    chk("rr_doe", n_doe, 0);

    // Flash write followed by Ethernet read, back to back
    adr = {23'h000ABC, 23'h000789}; wdt = {32'h0, 32'h12345678}; we = 2'b01;
    bus_d_i = 32'hCAFEF00D; req = 2'b11;
    mon_clear(); mon_run(1); req = 2'b10; mon_run(8); req = 2'b00; mon_run(8);
    chk("bb_ack_count", ack_t.size(), 2);
    if (ack_t.size() == 2) begin
      chk("bb_flash_ack", {ack_w[0], 8'(ack_t[0])}, {2'b01, 8'd6});
      chk("bb_enet_ack", {ack_w[1], 8'(ack_t[1])}, {2'b10, 8'd13});
    end
    chk("bb_turn", {doe_a[7], ce_a[7], ben_a[7], ce_a[8], ben_a[8]}, {1'b0, 1'b1, 4'hF, 1'b1, 4'hF});
    chk("bb_doe_cycles", n_doe, 6);
    chk("bb_we_rd", {8'(n_we), 8'(n_rd)}, {8'd4, 8'd3});
    chk("bb_overlap", overlap + dead_viol, 0);
    chk("bb_rdt", rdt, 32'hCAFEF00D);

    // Reset during flash STROBE
    adr = {23'h0, 23'h000321}; we = 2'b00; bus_d_i = 32'h0BADF00D; req = 2'b01;
    mon_clear(); mon_run(2);
    chk("ra_in_strobe", oe_a[2], 1'b0);
    #2 rst = 1'b1;
    #1;
    chk("ra_oe_now", flash_oe_n, 1'b1);
    chk("ra_doe_now", bus_d_oe, 1'b0);
    chk("ra_ce_now", flash_ce_n, 1'b1);
    mon_clear(); mon_run(3);
    chk("ra_no_ack", ack_t.size(), 0);
    chk("ra_idle", n_ce + n_oe, 0);
    chk("ra_rdt", rdt, 32'h0);
    rst = 1'b0;
    mon_clear(); mon_run(1);
    chk("ra_restart_setup", {ce_a[1], oe_a[1]}, 2'b01);
    req = 2'b00; mon_run(9);
    chk("ra_ce_cycles", n_ce, 6);
    chk("ra_ack_count", ack_t.size(), 1);
    if (ack_t.size() == 1) chk("ra_ack_time", ack_t[0], 6);
    chk("ra_rdt_new", rdt, 32'h0BADF00D);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: observed no finish, expected finish");
    $fatal(1, "timeout");
  end
endmodule
